reaction_sequencer: RTL and testbench

REACTION_SEQUENCER -- requirements
Module: reaction_sequencer

---
 rtl/reaction_sequencer.sv | 144 ++++++++++++++
 tb/tb_reaction_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: random pre-go delay, 3-digit BCD millisecond score,
// high-score display window and foul handling for early presses.
module reaction_sequencer #(
    parameter int WAIT_MIN = 1000,
    parameter int SHOW_MS  = 3000,
    parameter int FOUL_MS  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1khz,
    input  logic       key_start,
    input  logic       key_react,
    output logic [3:0] out_state,
    output logic       led_go,
    output logic [3:0] score_a,
    output logic [3:0] score_b,
    output logic [3:0] score_c,
    output logic       score_valid,
    output logic       hs_en,
    output logic       foul
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_WAIT = 4'd1,
        S_TIME = 4'd2,
        S_SHOW = 4'd3,
        S_FOUL = 4'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsrNext;
    logic [15:0] r_cnt;
    logic [3:0]  r_ones;
    logic [3:0]  r_tens;
    logic [3:0]  r_hund;
    logic        r_valid;
    logic        w_cntDone;
    logic        w_scoreMax;
    logic        w_enterTime;
    logic        w_scoreInc;

    // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed keeps it off the all-zero lockup
    assign w_lfsrNext  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_cntDone   = (r_cnt == 16'd1);
    assign w_scoreMax  = (r_ones == 4'd9) && (r_tens == 4'd9) && (r_hund == 4'd9);
    assign w_enterTime = (r_state == S_WAIT) && !key_react && tick_1khz && w_cntDone;
    assign w_scoreInc  = (r_state == S_TIME) && tick_1khz && !key_react && !w_scoreMax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (key_start) w_next = S_WAIT;
            S_WAIT: begin
                if (key_react) begin
                    w_next = S_FOUL;
                end else if (tick_1khz && w_cntDone) begin
                    w_next = S_TIME;
                end
            end
            S_TIME: if (key_react) w_next = S_SHOW;
            S_SHOW: if (tick_1khz && w_cntDone) w_next = S_IDLE;
            S_FOUL: if (tick_1khz && w_cntDone) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr  <= 16'hACE1;
            r_cnt   <= 16'd0;
            r_valid <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsrNext;
            r_valid <= (r_state == S_TIME) && key_react;
            case (r_state)
                S_IDLE: begin
                    if (key_start) r_cnt <= 16'(WAIT_MIN) + {5'd0, r_lfsr[10:0]};
                end
                S_WAIT: begin
                    if (key_react) begin
                        r_cnt <= 16'(FOUL_MS);
                    end else if (tick_1khz) begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_TIME: begin
                    if (key_react) r_cnt <= 16'(SHOW_MS);
                end
                S_SHOW, S_FOUL: begin
                    if (tick_1khz) r_cnt <= r_cnt - 16'd1;
                end
                default: r_cnt <= 16'd0;
            endcase
        end
    end

    // Score only moves while timing; a reaction in the same cycle as a tick freezes it first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
            r_hund <= 4'd0;
        end else if (w_enterTime) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
            r_hund <= 4'd0;
        end else if (w_scoreInc) begin
            if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                if (r_tens == 4'd9) begin
                    r_tens <= 4'd0;
                    r_hund <= r_hund + 4'd1;
                end else begin
                    r_tens <= r_tens + 4'd1;
                end
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    always_comb begin
        out_state   = r_state;
        led_go      = (r_state == S_TIME);
        hs_en       = (r_state == S_SHOW);
        foul        = (r_state == S_FOUL);
        score_valid = r_valid;
        score_a     = r_ones;
        score_b     = r_tens;
        score_c     = r_hund;
    end

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer: directed rounds plus random key presses,
// all compared every cycle against an integer-score reference model.
module tb_reaction_sequencer;

    localparam int WAIT_MIN = 4;
    localparam int SHOW_MS  = 5;
    localparam int FOUL_MS  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1khz = 1'b0;
    logic       key_start = 1'b0;
    logic       key_react = 1'b0;
    logic [3:0] out_state;
    logic       led_go;
    logic [3:0] score_a;
    logic [3:0] score_b;
    logic [3:0] score_c;
    logic       score_valid;
    logic       hs_en;
    logic       foul;

    int testsRun = 0;
    int testsFailed = 0;
    int cycle = 0;

    // Reference model: state code, remaining ms, score as a plain integer 0..999
    int          mState;
    int          mCnt;
    int          mScore;
    bit          mValid;
    logic [15:0] mLfsr;

    reaction_sequencer #(
        .WAIT_MIN(WAIT_MIN),
        .SHOW_MS (SHOW_MS),
        .FOUL_MS (FOUL_MS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1khz  (tick_1khz),
        .key_start  (key_start),
        .key_react  (key_react),
        .out_state  (out_state),
        .led_go     (led_go),
        .score_a    (score_a),
        .score_b    (score_b),
        .score_c    (score_c),
        .score_valid(score_valid),
        .hs_en      (hs_en),
        .foul       (foul)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    function automatic int toBcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int obsScore();
        return int'({score_c, score_b, score_a});
    endfunction

    function automatic logic [15:0] lfsrAdvance(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic modelReset();
        mState = 0;
        mCnt   = 0;
        mScore = 0;
        mValid = 1'b0;
        mLfsr  = 16'hACE1;
    endtask

    task automatic modelStep(input bit s, input bit r, input bit t);
        mValid = 1'b0;
        case (mState)
            0: if (s) begin
                mState = 1;
                mCnt   = WAIT_MIN + int'(mLfsr[10:0]);
            end
            1: if (r) begin
                mState = 4;
                mCnt   = FOUL_MS;
            end else if (t) begin
                if (mCnt == 1) begin
                    mState = 2;
                    mScore = 0;
                end else begin
                    mCnt = mCnt - 1;
                end
            end
            2: if (r) begin
                mState = 3;
                mValid = 1'b1;
                mCnt   = SHOW_MS;
            end else if (t && mScore < 999) begin
                mScore = mScore + 1;
            end
            default: if (t) begin
                if (mCnt == 1) mState = 0;
                else mCnt = mCnt - 1;
            end
        endcase
        mLfsr = lfsrAdvance(mLfsr);
    endtask

    task automatic compareAll();
        checkOutput("state", int'(out_state), mState);
        checkOutput("ledGo", int'(led_go), int'(mState == 2));
        checkOutput("hsEn", int'(hs_en), int'(mState == 3));
        checkOutput("foul", int'(foul), int'(mState == 4));
        checkOutput("valid", int'(score_valid), int'(mValid));
        checkOutput("score", obsScore(), toBcd(mScore));
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge
    task automatic applyStimulus(input bit s, input bit r);
        bit t;
        t = (cycle % 4 == 3);
        key_start = s;
        key_react = r;
        tick_1khz = t;
        @(posedge clk);
        modelStep(s, r, t);
        cycle++;
        @(negedge clk);
        compareAll();
    endtask

    task automatic doReset();
        key_start = 1'b0;
        key_react = 1'b0;
        tick_1khz = 1'b0;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        checkOutput("rstState", int'(out_state), 0);
        checkOutput("rstScore", obsScore(), 0);
        checkOutput("rstValid", int'(score_valid), 0);
        @(negedge clk);
        compareAll();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic runUntilState(input int target, input int budget, input string tag);
        int n = 0;
        while (mState != target && n < budget) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput(tag, int'(out_state), target);
    endtask

    task automatic runUntilScore(input int target, input int budget, input string tag);
        int n = 0;
        while (mScore != target && n < budget) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        checkOutput(tag, obsScore(), toBcd(target));
    endtask

    task automatic waitLfsr(input int limit);
        int n = 0;
        while (int'(mLfsr[10:0]) >= limit && n < 8000) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        bit s;
        bit r;

        modelReset();
        #1;
        compareAll();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("idleAfterRelease", int'(out_state), 0);

        // Normal round, with start and react together in IDLE
        waitLfsr(4);
        applyStimulus(1'b1, 1'b1);
        checkOutput("startWins", int'(out_state), 1);
        runUntilState(2, 9000, "reachTime");
        checkOutput("timeScoreClr", obsScore(), 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ignStartTime", int'(out_state), 2);
        runUntilScore(12, 200, "score12");
        applyStimulus(1'b0, 1'b1);
        checkOutput("showState", int'(out_state), 3);
        checkOutput("showScore", obsScore(), 'h012);
        checkOutput("validPulse", int'(score_valid), 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("validDrop", int'(score_valid), 0);
        checkOutput("ignShow", int'(out_state), 3);
        runUntilState(0, 100, "showToIdle");
        checkOutput("holdScore", obsScore(), 'h012);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ignReactIdle", int'(out_state), 0);

        // Early press
        waitLfsr(64);
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("foulState", int'(out_state), 4);
        checkOutput("foulFlag", int'(foul), 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("ignStartFoul", int'(out_state), 4);
        runUntilState(0, 100, "foulToIdle");
        checkOutput("foulScore", obsScore(), 'h012);

        // React coinciding with the final WAIT tick
        waitLfsr(8);
        applyStimulus(1'b1, 1'b0);
        n = 0;
        while (!(mState == 1 && mCnt == 1 && cycle % 4 == 3) && n < 9000) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("simWaitFoul", int'(out_state), 4);
        runUntilState(0, 100, "simFoulIdle");

        // React coinciding with a TIME tick at 041
        waitLfsr(8);
        applyStimulus(1'b1, 1'b0);
        runUntilState(2, 9000, "reachTime41");
        n = 0;
        while (!(mScore == 41 && cycle % 4 == 3) && n < 400) begin
            applyStimulus(1'b0, 1'b0);
            n++;
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("simTimeShow", int'(out_state), 3);
        checkOutput("simTimeScore", obsScore(), 'h041);
        runUntilState(0, 100, "simShowIdle");

        // Saturation at 999
        waitLfsr(8);
        applyStimulus(1'b1, 1'b0);
        runUntilState(2, 9000, "reachTimeSat");
        repeat (4400) applyStimulus(1'b0, 1'b0);
        checkOutput("satState", int'(out_state), 2);
        checkOutput("satScore", obsScore(), 'h999);
        checkOutput("satLed", int'(led_go), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("satShow", int'(out_state), 3);
        checkOutput("satShowScore", obsScore(), 'h999);
        runUntilState(0, 100, "satIdle");

        // Reset mid-TIME at 007, then a clean restart
        waitLfsr(8);
        applyStimulus(1'b1, 1'b0);
        runUntilState(2, 9000, "reachTimeRst");
        runUntilScore(7, 100, "score7");
        doReset();
        applyStimulus(1'b0, 1'b0);
        checkOutput("postRstIdle", int'(out_state), 0);
        waitLfsr(8);
        applyStimulus(1'b1, 1'b0);
        checkOutput("restartWait", int'(out_state), 1);
        runUntilState(2, 9000, "restartTime");
        applyStimulus(1'b0, 1'b1);
        checkOutput("restartShow", int'(out_state), 3);
        runUntilState(0, 100, "restartIdle");

        // Random presses with occasional asynchronous resets
        for (int i = 0; i < 12000; i++) begin
            s = (int'(mLfsr[10:0]) < 16) || ($urandom % 50 == 0);
            r = ($urandom % 150 == 0);
            if ($urandom % 4000 == 0) begin
                doReset();
            end
            applyStimulus(s, r);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
